// File: rtl/alu_div.sv
// Multi-cycle unsigned restoring divider (IDLE/CALC/DONE), one quotient bit per CALC cycle.
// A zero divisor finishes immediately with an all-ones quotient, the dividend as remainder, and the carry flag set.
module alu_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] op2_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             cout_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] divisor_r;
  logic [CW-1:0]    count_r;
  logic             cout_r;

  logic             accept_s;
  logic             step_s;
  logic             zero_div_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] trial_s;
  logic             borrow_s;
  logic [WIDTH-1:0] rem_step_s;
  logic [WIDTH-1:0] quot_shift_s;
  logic [WIDTH-1:0] quot_step_s;
  logic             unused_s;

  assign zero_div_s = (op2_i == {WIDTH{1'b0}});

  // Next-state decode: start is only looked at in IDLE, DONE always falls back to IDLE.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          accept_s = 1'b1;
          if (zero_div_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = CALC;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        step_s = 1'b1;
        if (count_r == LAST_STEP) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // One restoring step: shift {rem,quot} left, trial-subtract, keep or restore.
  always_comb begin
    shifted_s    = {rem_r, quot_r[WIDTH-1]};
    trial_s      = {1'b0, shifted_s} - {2'b00, divisor_r};
    borrow_s     = trial_s[WIDTH+1];
    quot_shift_s = quot_r << 1;
    if (borrow_s) begin
      rem_step_s  = shifted_s[WIDTH-1:0];
      quot_step_s = quot_shift_s;
    end else begin
      rem_step_s  = trial_s[WIDTH-1:0];
      quot_step_s = quot_shift_s | {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // The difference never reaches bit WIDTH when kept, since the partial remainder stays below the divisor.
  assign unused_s = trial_s[WIDTH];

  // State register with registered busy/done flags derived from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Datapath: operand capture on accept, one shift-subtract per CALC cycle, hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_r     <= {WIDTH{1'b0}};
      quot_r    <= {WIDTH{1'b0}};
      divisor_r <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      cout_r    <= 1'b0;
    end else if (accept_s) begin
      divisor_r <= op2_i;
      count_r   <= {CW{1'b0}};
      if (zero_div_s) begin
        quot_r <= {WIDTH{1'b1}};
        rem_r  <= rs_i;
        cout_r <= 1'b1;
      end else begin
        quot_r <= rs_i;
        rem_r  <= {WIDTH{1'b0}};
        cout_r <= 1'b0;
      end
    end else if (step_s) begin
      rem_r   <= rem_step_s;
      quot_r  <= quot_step_s;
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      rem_r   <= rem_r;
      quot_r  <= quot_r;
      count_r <= count_r;
    end
  end

  assign quot_o = quot_r;
  assign rem_o  = rem_r;
  assign cout_o = cout_r;
  assign busy_o = busy_r;
  assign done_o = done_r;

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: directed vector table plus hand-written multi-cycle sequences.
module tb_alu_div;
  localparam int W = 8;

  logic         clk;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] rs_i;
  logic [W-1:0] op2_i;
  logic [W-1:0] quot_o;
  logic [W-1:0] rem_o;
  logic         cout_o;
  logic         busy_o;
  logic         done_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       c;
  } vec_t;

  vec_t vecs [13];

  alu_div #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .start_i(start_i),
    .rs_i   (rs_i),
    .op2_i  (op2_i),
    .quot_o (quot_o),
    .rem_o  (rem_o),
    .cout_o (cout_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample from the current point until done_o is seen (bounded); returns cycles waited and busy samples.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int k = 0; k <= 20; k++) begin
      lat = k;
      if (busy_o) busy_cnt++;
      if (done_o) break;
      tick();
    end
  endtask

  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r, input logic c);
    int lat;
    int bc;
    rs_i = a; op2_i = b; start_i = 1'b1;
    tick();
    start_i = 1'b0; rs_i = ~a; op2_i = ~b;
    wait_done(lat, bc);
    chk({tag, " latency"}, lat, (b == 8'd0) ? 0 : W);
    chk({tag, " busy_cycles"}, bc, (b == 8'd0) ? 1 : W + 1);
    chk({tag, " quot"}, quot_o, q);
    chk({tag, " rem"}, rem_o, r);
    chk({tag, " cout"}, cout_o, c);
    tick();
    chk({tag, " done_after"}, done_o, 1'b0);
    chk({tag, " busy_after"}, busy_o, 1'b0);
    chk({tag, " quot_hold"}, quot_o, q);
  endtask

  initial begin
    int lat, bc, c1, c2, pulses;
    logic [7:0] ra, rb, rq, rr;

    vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[1]  = '{8'd5,   8'd0,   8'd255, 8'd5,   1'b1};
    vecs[2]  = '{8'd3,   8'd9,   8'd0,   8'd3,   1'b0};
    vecs[3]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[4]  = '{8'd100, 8'd10,  8'd10,  8'd0,   1'b0};
    vecs[5]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[6]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[7]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vecs[8]  = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0};
    vecs[9]  = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
    vecs[10] = '{8'd17,  8'd16,  8'd1,   8'd1,   1'b0};
    vecs[11] = '{8'd99,  8'd2,   8'd49,  8'd1,   1'b0};
    vecs[12] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};

    // Reset with start held high: reset must win.
    rst_i = 1'b1; start_i = 1'b1; rs_i = 8'd40; op2_i = 8'd3;
    tick();
    tick();
    chk("reset quot", quot_o, 8'd0);
    chk("reset rem", rem_o, 8'd0);
    chk("reset cout", cout_o, 1'b0);
    chk("reset busy", busy_o, 1'b0);
    chk("reset done", done_o, 1'b0);
    rst_i = 1'b0; start_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].c);
    end

    // Back-to-back with start held high: second accept exactly W+2 cycles after the first.
    rs_i = 8'd3; op2_i = 8'd9; start_i = 1'b1;
    tick();
    c1 = cyc;
    rs_i = 8'd255; op2_i = 8'd1;
    wait_done(lat, bc);
    chk("b2b first latency", lat, W);
    chk("b2b first quot", quot_o, 8'd0);
    chk("b2b first rem", rem_o, 8'd3);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (busy_o) break;
    end
    c2 = cyc;
    chk("b2b issue interval", c2 - c1, W + 2);
    start_i = 1'b0; rs_i = 8'd0; op2_i = 8'd0;
    wait_done(lat, bc);
    chk("b2b second latency", lat, W);
    chk("b2b second quot", quot_o, 8'd255);
    chk("b2b second rem", rem_o, 8'd0);
    chk("b2b second cout", cout_o, 1'b0);
    tick();

    // Operand changes and a start pulse during CALC must be ignored.
    rs_i = 8'd60; op2_i = 8'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0; rs_i = 8'd1; op2_i = 8'd1;
    tick();
    tick();
    start_i = 1'b1; rs_i = 8'd9; op2_i = 8'd0;
    tick();
    start_i = 1'b0;
    wait_done(lat, bc);
    chk("calc_start latency", lat, W - 3);
    chk("calc_start quot", quot_o, 8'd8);
    chk("calc_start rem", rem_o, 8'd4);
    chk("calc_start cout", cout_o, 1'b0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done_o || busy_o) pulses++;
    end
    chk("calc_start not_queued", pulses, 0);

    // Reset during the 4th CALC cycle aborts without a done pulse.
    rs_i = 8'd50; op2_i = 8'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    chk("abort quot", quot_o, 8'd0);
    chk("abort rem", rem_o, 8'd0);
    chk("abort cout", cout_o, 1'b0);
    chk("abort busy", busy_o, 1'b0);
    chk("abort done", done_o, 1'b0);
    rst_i = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done_o) pulses++;
    end
    chk("abort no_done", pulses, 0);
    run_div("after_reset", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0);

    // Random pairs against a bench-side reference.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      if (i % 16 == 0) rb = 8'd0;
      else if (i % 16 == 1) rb = 8'd1;
      else rb = 8'($urandom_range(0, 255));
      if (rb == 8'd0) begin
        rq = 8'd255; rr = ra;
      end else begin
        rq = ra / rb; rr = ra % rb;
      end
      run_div($sformatf("rand%0d_%0d_%0d", i, ra, rb), ra, rb, rq, rr, (rb == 8'd0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
